// File: rtl/imuldiv_muldiv_frontend_pkg.sv
// Shared definitions for the mul/div frontend: fn encodings, tag width helper
// and the decode that decides which half of the 64-bit unit result to return.
// Optional feature macro: IMULDIV_MULDIV_FRONTEND_MULH_EN (fn 5 = mulh).
package imuldiv_muldiv_frontend_pkg;

  typedef enum logic [2:0] {
    FN_MUL  = 3'd0,
    FN_DIV  = 3'd1,
    FN_DIVU = 3'd2,
    FN_REM  = 3'd3,
    FN_REMU = 3'd4,
    FN_MULH = 3'd5
  } muldiv_fn_e;

  // Each tag carries the destination register plus one half-select bit.
  localparam int TAG_EXTRA_W = 1;

  function automatic int tag_width(input int rd_w);
    return rd_w + TAG_EXTRA_W;
  endfunction

  // Remainders live in the upper half of the unit result; mulh (when enabled)
  // returns the upper half of the product.
  function automatic logic fn_sel_hi(input logic [2:0] fn);
    logic hi;
    hi = (fn == FN_REM) || (fn == FN_REMU);
`ifdef IMULDIV_MULDIV_FRONTEND_MULH_EN
    hi = hi || (fn == FN_MULH);
`endif
    return hi;
  endfunction

  // The unit only knows about plain mul; mulh is a mul whose high half we keep.
  function automatic logic [2:0] fn_to_unit(input logic [2:0] fn);
    logic [2:0] ufn;
    ufn = fn;
`ifdef IMULDIV_MULDIV_FRONTEND_MULH_EN
    if (fn == FN_MULH) ufn = FN_MUL;
`endif
    return ufn;
  endfunction

endpackage

// File: rtl/imuldiv_TagQueue.sv
// Small in-order FIFO holding one tag per outstanding mul/div operation.
// Pointers wrap naturally (DEPTH is a power of two); count is one bit wider
// so that full and empty are distinguishable.
module imuldiv_TagQueue #(
  parameter int DEPTH = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_DEPTH);
  assign empty    = (count == '0);
  assign do_push  = push & !full;
  assign do_pop   = pop & !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps count steady.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/imuldiv_muldiv_frontend.sv
// Frontend between the execute stage and the iterative mul/div unit.
// Requests pass straight through to the unit; a tag FIFO remembers the
// destination register and which result half to keep; responses land in a
// registered writeback stage.
// Optional feature macro: IMULDIV_MULDIV_FRONTEND_MULH_EN (fn 5 = mulh).
module imuldiv_muldiv_frontend
  import imuldiv_muldiv_frontend_pkg::*;
#(
  parameter int TAG_DEPTH = 2,
  parameter int RD_W      = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req_msg_fn,
  input  logic [31:0]     req_msg_a,
  input  logic [31:0]     req_msg_b,
  input  logic [RD_W-1:0] req_msg_rd,
  input  logic            req_val,
  output logic            req_rdy,
  output logic [2:0]      muldivreq_msg_fn,
  output logic [31:0]     muldivreq_msg_a,
  output logic [31:0]     muldivreq_msg_b,
  output logic            muldivreq_val,
  input  logic            muldivreq_rdy,
  input  logic [63:0]     muldivresp_msg_result,
  input  logic            muldivresp_val,
  output logic            muldivresp_rdy,
  output logic [31:0]     wb_msg_data,
  output logic [RD_W-1:0] wb_msg_rd,
  output logic            wb_val,
  input  logic            wb_rdy
);

  localparam int TAG_W = tag_width(RD_W);

  logic             tag_full;
  logic             tag_empty;
  logic             req_fire;
  logic             resp_fire;
  logic [TAG_W-1:0] push_tag;
  logic [TAG_W-1:0] head_tag;
  logic [RD_W-1:0]  head_rd;
  logic             head_hi;

  // Request path: no added latency; a full tag FIFO stalls both sides even
  // if a response frees a slot in the same cycle.
  assign muldivreq_msg_fn = fn_to_unit(req_msg_fn);
  assign muldivreq_msg_a  = req_msg_a;
  assign muldivreq_msg_b  = req_msg_b;
  assign muldivreq_val    = req_val & !tag_full;
  assign req_rdy          = muldivreq_rdy & !tag_full;
  assign req_fire         = req_val & req_rdy;
  assign push_tag         = {req_msg_rd, fn_sel_hi(req_msg_fn)};

  // Response path: only accept when a tag exists and the output stage can take it.
  assign muldivresp_rdy = !tag_empty & (!wb_val | wb_rdy);
  assign resp_fire      = muldivresp_val & muldivresp_rdy;
  assign head_rd        = head_tag[TAG_W-1:1];
  assign head_hi        = head_tag[0];

  imuldiv_TagQueue #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (push_tag),
    .pop       (resp_fire),
    .pop_data  (head_tag),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Writeback register: loads on response fire, drains on wb fire, holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_val      <= 1'b0;
      wb_msg_data <= '0;
      wb_msg_rd   <= '0;
    end else if (resp_fire) begin
      wb_val      <= 1'b1;
      wb_msg_data <= head_hi ? muldivresp_msg_result[63:32] : muldivresp_msg_result[31:0];
      wb_msg_rd   <= head_rd;
    end else if (wb_val && wb_rdy) begin
      wb_val      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imuldiv_muldiv_frontend.sv
// Directed bench for imuldiv_muldiv_frontend; the bench plays the mul/div unit
// and the writeback consumer. Build with +define+IMULDIV_MULDIV_FRONTEND_MULH_EN
// to exercise mulh.
module tb_imuldiv_muldiv_frontend;

  logic        clk;
  logic        reset;
  logic [2:0]  req_msg_fn;
  logic [31:0] req_msg_a;
  logic [31:0] req_msg_b;
  logic [4:0]  req_msg_rd;
  logic        req_val;
  logic        req_rdy;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a;
  logic [31:0] muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy;
  logic [63:0] muldivresp_msg_result;
  logic        muldivresp_val;
  logic        muldivresp_rdy;
  logic [31:0] wb_msg_data;
  logic [4:0]  wb_msg_rd;
  logic        wb_val;
  logic        wb_rdy;

  int vec_count;
  int miscompares;

  imuldiv_muldiv_frontend #(
    .TAG_DEPTH (2),
    .RD_W      (5)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_msg_fn            (req_msg_fn),
    .req_msg_a             (req_msg_a),
    .req_msg_b             (req_msg_b),
    .req_msg_rd            (req_msg_rd),
    .req_val               (req_val),
    .req_rdy               (req_rdy),
    .muldivreq_msg_fn      (muldivreq_msg_fn),
    .muldivreq_msg_a       (muldivreq_msg_a),
    .muldivreq_msg_b       (muldivreq_msg_b),
    .muldivreq_val         (muldivreq_val),
    .muldivreq_rdy         (muldivreq_rdy),
    .muldivresp_msg_result (muldivresp_msg_result),
    .muldivresp_val        (muldivresp_val),
    .muldivresp_rdy        (muldivresp_rdy),
    .wb_msg_data           (wb_msg_data),
    .wb_msg_rd             (wb_msg_rd),
    .wb_val                (wb_val),
    .wb_rdy                (wb_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd,
                               input logic val);
    req_msg_fn = fn;
    req_msg_a  = a;
    req_msg_b  = b;
    req_msg_rd = rd;
    req_val    = val;
  endtask

  task automatic respond(input logic [63:0] result, input logic val);
    muldivresp_msg_result = result;
    muldivresp_val        = val;
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_count   = 0;
    miscompares = 0;
    reset       = 1'b1;
    muldivreq_rdy = 1'b0;
    wb_rdy      = 1'b1;
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    respond(64'h0, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    checkOutput("rst_wb_val",  {63'h0, wb_val}, 64'h0);
    checkOutput("rst_wb_data", {32'h0, wb_msg_data}, 64'h0);
    checkOutput("rst_wb_rd",   {59'h0, wb_msg_rd}, 64'h0);
    checkOutput("rst_resp_rdy", {63'h0, muldivresp_rdy}, 64'h0);
    muldivreq_rdy = 1'b1;
    #1;
    checkOutput("rst_req_rdy", {63'h0, req_rdy}, 64'h1);

    // mul 8 x 3 -> rd 7
    applyStimulus(3'd0, 32'h8, 32'h3, 5'd7, 1'b1);
    #1;
    checkOutput("mul_unit_val", {63'h0, muldivreq_val}, 64'h1);
    checkOutput("mul_unit_fn",  {61'h0, muldivreq_msg_fn}, 64'h0);
    checkOutput("mul_unit_a",   {32'h0, muldivreq_msg_a}, 64'h8);
    checkOutput("mul_unit_b",   {32'h0, muldivreq_msg_b}, 64'h3);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    respond(64'h0000_0000_0000_0018, 1'b1);
    #1;
    checkOutput("mul_resp_rdy", {63'h0, muldivresp_rdy}, 64'h1);
    checkOutput("mul_wb_early", {63'h0, wb_val}, 64'h0);
    step();
    respond(64'h0, 1'b0);
    checkOutput("mul_wb_val",  {63'h0, wb_val}, 64'h1);
    checkOutput("mul_wb_data", {32'h0, wb_msg_data}, 64'h18);
    checkOutput("mul_wb_rd",   {59'h0, wb_msg_rd}, 64'd7);
    step();
    checkOutput("mul_wb_drain", {63'h0, wb_val}, 64'h0);

    // rem then divu with the same operands; FIFO fills to depth 2
    applyStimulus(3'd3, 32'h222, 32'h32, 5'd3, 1'b1);
    step();
    applyStimulus(3'd2, 32'h222, 32'h32, 5'd4, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    checkOutput("full_req_rdy", {63'h0, req_rdy}, 64'h0);
    respond(64'h0000002e_0000000a, 1'b1);
    step();
    checkOutput("rem_wb_data", {32'h0, wb_msg_data}, 64'h2e);
    checkOutput("rem_wb_rd",   {59'h0, wb_msg_rd}, 64'd3);
    step();
    respond(64'h0, 1'b0);
    checkOutput("divu_wb_val",  {63'h0, wb_val}, 64'h1);
    checkOutput("divu_wb_data", {32'h0, wb_msg_data}, 64'h0a);
    checkOutput("divu_wb_rd",   {59'h0, wb_msg_rd}, 64'd4);
    step();

    // three ops with responses held: third stalls until one response drains
    applyStimulus(3'd0, 32'h1, 32'h1, 5'd1, 1'b1);
    step();
    applyStimulus(3'd0, 32'h2, 32'h1, 5'd2, 1'b1);
    step();
    applyStimulus(3'd0, 32'h3, 32'h1, 5'd3, 1'b1);
    #1;
    checkOutput("stall_req_rdy", {63'h0, req_rdy}, 64'h0);
    checkOutput("stall_unit_val", {63'h0, muldivreq_val}, 64'h0);
    step();
    checkOutput("stall_req_rdy2", {63'h0, req_rdy}, 64'h0);
    respond(64'h0000_0000_0000_1111, 1'b1);
    step();
    checkOutput("release_req_rdy", {63'h0, req_rdy}, 64'h1);
    checkOutput("order1_rd",   {59'h0, wb_msg_rd}, 64'd1);
    checkOutput("order1_data", {32'h0, wb_msg_data}, 64'h1111);
    respond(64'h0000_0000_0000_2222, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    checkOutput("order2_rd",   {59'h0, wb_msg_rd}, 64'd2);
    checkOutput("order2_data", {32'h0, wb_msg_data}, 64'h2222);
    respond(64'h0000_0000_0000_3333, 1'b1);
    step();
    respond(64'h0, 1'b0);
    checkOutput("order3_rd",   {59'h0, wb_msg_rd}, 64'd3);
    checkOutput("order3_data", {32'h0, wb_msg_data}, 64'h3333);
    step();
    checkOutput("order_drain", {63'h0, wb_val}, 64'h0);

    // writeback back-pressure with two responses pending
    applyStimulus(3'd3, 32'h0, 32'h0, 5'd10, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd11, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    wb_rdy = 1'b0;
    respond(64'haaaaaaaa_55555555, 1'b1);
    step();
    respond(64'h00000000_12345678, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_wb_val",   {63'h0, wb_val}, 64'h1);
      checkOutput("bp_wb_data",  {32'h0, wb_msg_data}, 64'haaaaaaaa);
      checkOutput("bp_wb_rd",    {59'h0, wb_msg_rd}, 64'd10);
      checkOutput("bp_resp_rdy", {63'h0, muldivresp_rdy}, 64'h0);
      step();
    end
    wb_rdy = 1'b1;
    #1;
    checkOutput("bp_release_rdy", {63'h0, muldivresp_rdy}, 64'h1);
    step();
    respond(64'h0, 1'b0);
    checkOutput("bp_b2b_val",  {63'h0, wb_val}, 64'h1);
    checkOutput("bp_b2b_data", {32'h0, wb_msg_data}, 64'h12345678);
    checkOutput("bp_b2b_rd",   {59'h0, wb_msg_rd}, 64'd11);
    step();
    checkOutput("bp_drain", {63'h0, wb_val}, 64'h0);

    // reset with two ops outstanding and writeback holding a result
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd20, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd21, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd22, 1'b1);
    wb_rdy = 1'b0;
    respond(64'h0000_0000_0000_00aa, 1'b1);
    step();
    respond(64'h0, 1'b0);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    checkOutput("pre_rst_wb_val", {63'h0, wb_val}, 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    respond(64'h0000_0000_0000_00bb, 1'b1);
    #1;
    checkOutput("post_rst_wb_val",   {63'h0, wb_val}, 64'h0);
    checkOutput("post_rst_wb_data",  {32'h0, wb_msg_data}, 64'h0);
    checkOutput("post_rst_wb_rd",    {59'h0, wb_msg_rd}, 64'h0);
    checkOutput("post_rst_resp_rdy", {63'h0, muldivresp_rdy}, 64'h0);
    checkOutput("post_rst_req_rdy",  {63'h0, req_rdy}, 64'h1);
    respond(64'h0, 1'b0);
    wb_rdy = 1'b1;
    applyStimulus(3'd0, 32'h5, 32'h5, 5'd9, 1'b1);
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    respond(64'h0000_0000_0000_0019, 1'b1);
    step();
    respond(64'h0, 1'b0);
    checkOutput("post_rst_new_rd",   {59'h0, wb_msg_rd}, 64'd9);
    checkOutput("post_rst_new_data", {32'h0, wb_msg_data}, 64'h19);
    step();

    // fn 5: mulh when enabled, otherwise an ordinary low-half passthrough
    applyStimulus(3'd5, 32'hdeadbeef, 32'h10000000, 5'd12, 1'b1);
    #1;
`ifdef IMULDIV_MULDIV_FRONTEND_MULH_EN
    checkOutput("fn5_unit_fn", {61'h0, muldivreq_msg_fn}, 64'd0);
`else
    checkOutput("fn5_unit_fn", {61'h0, muldivreq_msg_fn}, 64'd5);
`endif
    step();
    applyStimulus(3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    respond(64'hfdeadbee_f0000000, 1'b1);
    step();
    respond(64'h0, 1'b0);
`ifdef IMULDIV_MULDIV_FRONTEND_MULH_EN
    checkOutput("fn5_wb_data", {32'h0, wb_msg_data}, 64'hfdeadbee);
`else
    checkOutput("fn5_wb_data", {32'h0, wb_msg_data}, 64'hf0000000);
`endif
    checkOutput("fn5_wb_rd", {59'h0, wb_msg_rd}, 64'd12);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
